// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The state encoding is fixed at 3 bits so unused codes can be recovered.
package uart_pkg;

    localparam int UART_BYTE_W       = 8;
    localparam int UART_FRAME_CYCLES = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        GAP  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first asserted request searching
// upward from rr_ptr_i+1, wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    sel_o,
    output logic               any_o
);

    logic            found;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        any_o = |req_i;
        sel_o = '0;
        found = 1'b0;
        idx_w = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_w = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (!found && req_i[idx_w]) begin
                sel_o = idx_w;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT/SEND watchdog enabled by defining UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request while the UART reports tx_empty
// LOAD  | one-cycle load strobe and requester acknowledge
// WAIT  | enable held, waiting for the UART to go busy
// SEND  | enable held until the UART returns to empty
// GAP   | enforced idle time with enable low between frames
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                           txclk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           busy,
    output logic [ID_W-1:0]                cur_id,
    output logic                           frame_done,
    output logic                           tx_timeout_err,
    output logic                           ld_tx_data,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_enable,
    input  logic                           tx_empty
);

    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("uart_tx_arbiter: ID_W must equal clog2(NUM_REQ)");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam arb_state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic                   ld_q, ld_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   timeout_hit;
    logic                   abort;
    logic [ID_W-1:0]        sel;
    logic                   any;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;

    assign timeout_hit    = (to_cnt_q == '0);
    assign tx_timeout_err = to_err_q;
`else
    assign timeout_hit    = 1'b0;
    assign tx_timeout_err = 1'b0;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (sel),
        .any_o    (any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_id_d  = cur_id_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        abort     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        to_err_d  = to_err_q;
        if (state_q == WAIT || state_q == SEND) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                // A busy UART must never be loaded, even with requests pending.
                if (any && tx_empty) begin
                    state_d   = LOAD;
                    cur_id_d  = sel;
                    rr_ptr_d  = sel;
                    tx_data_d = req_data[int'(sel)*UART_BYTE_W +: UART_BYTE_W];
                end
            end
            LOAD: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            WAIT: begin
                if (!tx_empty) begin
                    state_d = SEND;
                end
                abort = timeout_hit;
            end
            SEND: begin
                if (tx_empty) begin
                    done_d  = 1'b1;
                    state_d = AFTER_FRAME;
                    gap_d   = GAP_LOAD;
                end else begin
                    abort = timeout_hit;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = AFTER_FRAME;
            gap_d   = GAP_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
            to_err_d = 1'b1;
`endif
        end

        // Outputs are registered from the next state so they line up with it.
        ld_d      = (state_d == LOAD);
        en_d      = (state_d == LOAD) || (state_d == WAIT) || (state_d == SEND);
        busy_d    = (state_d != IDLE);
        req_ack_d = ld_d ? (NUM_REQ'(1) << cur_id_d) : '0;
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= ID_W'(NUM_REQ - 1);
            cur_id_q  <= '0;
            tx_data_q <= '0;
            req_ack_q <= '0;
            ld_q      <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gap_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_id_q  <= cur_id_d;
            tx_data_q <= tx_data_d;
            req_ack_q <= req_ack_d;
            ld_q      <= ld_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gap_q     <= gap_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            to_err_q  <= to_err_d;
`endif
        end
    end

    assign req_ack    = req_ack_q;
    assign busy       = busy_q;
    assign cur_id     = cur_id_q;
    assign frame_done = done_q;
    assign ld_tx_data = ld_q;
    assign tx_data    = tx_data_q;
    assign tx_enable  = en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a 4-requester instance with a 2-cycle
// gap, and a 2-requester instance with no gap and a 5-cycle watchdog.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic txclk = 1'b0;
    logic reset = 1'b0;
    always #5 txclk = ~txclk;

    logic [3:0]  req_a  = '0;
    logic [31:0] data_a = '0;
    logic [3:0]  ack_a;
    logic        busy_a, done_a, err_a, ld_a, en_a, empty_a;
    logic [1:0]  id_a;
    logic [7:0]  txd_a;
    logic        force_a = 1'b0;
    int          ucnt_a;

    logic [1:0]  req_b  = '0;
    logic [15:0] data_b = '0;
    logic [1:0]  ack_b;
    logic        busy_b, done_b, err_b, ld_b, en_b, empty_b;
    logic [0:0]  id_b;
    logic [7:0]  txd_b;
    logic        force_b = 1'b0;
    int          ucnt_b;

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(32)) u_dut_a (
        .txclk(txclk), .reset(reset), .req(req_a), .req_data(data_a),
        .req_ack(ack_a), .busy(busy_a), .cur_id(id_a), .frame_done(done_a),
        .tx_timeout_err(err_a), .ld_tx_data(ld_a), .tx_data(txd_a),
        .tx_enable(en_a), .tx_empty(empty_a)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .ID_W(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(5)) u_dut_b (
        .txclk(txclk), .reset(reset), .req(req_b), .req_data(data_b),
        .req_ack(ack_b), .busy(busy_b), .cur_id(id_b), .frame_done(done_b),
        .tx_timeout_err(err_b), .ld_tx_data(ld_b), .tx_data(txd_b),
        .tx_enable(en_b), .tx_empty(empty_b)
    );

    // UART models: busy for UART_FRAME_CYCLES enabled cycles after a load.
    always @(posedge txclk or negedge reset) begin
        if (!reset)                      ucnt_a <= 0;
        else if (ld_a)                   ucnt_a <= UART_FRAME_CYCLES;
        else if (ucnt_a > 0 && en_a)     ucnt_a <= ucnt_a - 1;
    end
    assign empty_a = (ucnt_a == 0) && !force_a;

    always @(posedge txclk or negedge reset) begin
        if (!reset)                      ucnt_b <= 0;
        else if (ld_b)                   ucnt_b <= UART_FRAME_CYCLES;
        else if (ucnt_b > 0 && en_b)     ucnt_b <= ucnt_b - 1;
    end
    assign empty_b = (ucnt_b == 0) && !force_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   loads_a = 0;

    always @(negedge txclk) begin
        exp_t e;
        if (reset && ld_a) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_load actual id=%0d data=%0h required=no load", id_a, txd_a);
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", 32'(id_a), 32'(e.id));
                chk("sb_data", 32'(txd_a), 32'(e.data));
                chk("sb_ack", 32'(ack_a), 32'(4'b0001 << e.id));
                chk("sb_en", 32'(en_a), 32'd1);
            end
            loads_a++;
        end
        if (reset && ((ack_a != 4'b0000) != ld_a)) begin
            checks++;
            errors++;
            $display("FAIL sb_ack_outside_load actual ack=%0h ld=%0b required ack only with ld", ack_a, ld_a);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge txclk);
    endtask

    task automatic wait_a_idle(input string name);
        int n = 0;
        while (busy_a && n < 200) begin
            tick(1);
            n++;
        end
        chk(name, 32'(busy_a), 32'd0);
    endtask

    task automatic wait_loads(input int target, input string name);
        int n = 0;
        while (loads_a < target && n < 500) begin
            tick(1);
            n++;
        end
        chk(name, 32'(loads_a), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic done_seen;

        tick(2);
        chk("rst_outs_a", 32'({ack_a, busy_a, id_a, done_a, err_a, ld_a, txd_a, en_a}), 32'd0);
        chk("rst_outs_b", 32'({ack_b, busy_b, id_b, done_b, err_b, ld_b, txd_b, en_b}), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single request, requester 1, byte 0xA5.
        data_a[15:8] = 8'hA5;
        exp_q.push_back('{id: 2'd1, data: 8'hA5});
        req_a = 4'b0010;
        tick(1);
        chk("t1_latency", 32'(ld_a), 32'd1);
        req_a = 4'b0000;
        n = 0;
        while (!done_a && n < 50) begin
            tick(1);
            n++;
        end
        // WAIT + 9 SEND cycles with UART busy, one SEND cycle sampling empty, then done.
        chk("t1_done_lat", 32'(n), 32'd12);
        chk("t1_done_state", 32'({busy_a, en_a}), 32'b10);
        tick(1);
        chk("t1_gap2", 32'({busy_a, en_a, done_a}), 32'b100);
        tick(1);
        chk("t1_idle", 32'(busy_a), 32'd0);

        // Contention from a fresh pointer: 0,1,2,3,0.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        data_a = 32'h13121110;
        exp_q.push_back('{id: 2'd0, data: 8'h10});
        exp_q.push_back('{id: 2'd1, data: 8'h11});
        exp_q.push_back('{id: 2'd2, data: 8'h12});
        exp_q.push_back('{id: 2'd3, data: 8'h13});
        exp_q.push_back('{id: 2'd0, data: 8'h10});
        base = loads_a;
        req_a = 4'b1111;
        wait_loads(base + 5, "t2_loads");
        req_a = 4'b0000;
        wait_a_idle("t2_idle");

        // UART busy holds off the load.
        force_a = 1'b1;
        data_a[7:0] = 8'h5C;
        exp_q.push_back('{id: 2'd0, data: 8'h5C});
        req_a = 4'b0001;
        tick(5);
        chk("t3_hold", 32'({ld_a, busy_a}), 32'd0);
        force_a = 1'b0;
        tick(1);
        chk("t3_load", 32'(ld_a), 32'd1);
        req_a = 4'b0000;
        wait_a_idle("t3_idle");

        // Reset in the middle of SEND, then a pointer-sensitive request pair.
        data_a[15:8] = 8'h77;
        exp_q.push_back('{id: 2'd1, data: 8'h77});
        req_a = 4'b0010;
        tick(1);
        req_a = 4'b0000;
        tick(5);
        reset = 1'b0;
        #1;
        chk("t4_rst_outs", 32'({ack_a, busy_a, id_a, done_a, ld_a, txd_a, en_a}), 32'd0);
        @(negedge txclk);
        reset = 1'b1;
        tick(1);
        data_a[15:8]  = 8'h66;
        data_a[23:16] = 8'h3C;
        exp_q.push_back('{id: 2'd1, data: 8'h66});
        exp_q.push_back('{id: 2'd2, data: 8'h3C});
        base = loads_a;
        req_a = 4'b0110;
        wait_loads(base + 2, "t4_loads");
        req_a = 4'b0000;
        wait_a_idle("t4_idle");

        // No-gap instance: continuous lone requester reloads right after frame_done.
        data_b[7:0] = 8'hC3;
        req_b = 2'b01;
        n = 0;
        while (!done_b && n < 100) begin
            tick(1);
            n++;
        end
        chk("t5_done_seen", 32'(done_b), 32'd1);
        chk("t5_no_ld", 32'(ld_b), 32'd0);
        tick(1);
        chk("t5_reload", 32'({ld_b, ack_b, id_b, txd_b}), 32'({1'b1, 2'b01, 1'b0, 8'hC3}));
        req_b = 2'b00;
        n = 0;
        while (busy_b && n < 100) begin
            tick(1);
            n++;
        end
        chk("t5_idle", 32'(busy_b), 32'd0);

        // UART stuck busy after a load.
        data_b[15:8] = 8'h9E;
        req_b = 2'b10;
        n = 0;
        while (!ld_b && n < 20) begin
            tick(1);
            n++;
        end
        chk("t6_load", 32'({ld_b, id_b, txd_b}), 32'({1'b1, 1'b1, 8'h9E}));
        force_b = 1'b1;
        req_b = 2'b00;
        done_seen = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (en_b && n < 40) begin
            tick(1);
            n++;
            done_seen = done_seen | done_b;
        end
        // LOAD cycle plus five WAIT/SEND cycles before enable drops.
        chk("t6_en_cycles", 32'(n), 32'd6);
        chk("t6_err", 32'(err_b), 32'd1);
        chk("t6_busy", 32'(busy_b), 32'd0);
        repeat (10) begin
            tick(1);
            done_seen = done_seen | done_b;
        end
        chk("t6_err_sticky", 32'(err_b), 32'd1);
        chk("t6_no_done", 32'(done_seen), 32'd0);
`else
        repeat (40) begin
            tick(1);
            done_seen = done_seen | done_b;
        end
        chk("t6_hang", 32'({en_b, busy_b, err_b}), 32'b110);
        chk("t6_no_done", 32'(done_seen), 32'd0);
`endif
        reset = 1'b0;
        tick(1);
        force_b = 1'b0;
        reset = 1'b1;
        tick(1);
        chk("t6_err_cleared", 32'({err_b, busy_b}), 32'd0);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
